// File: rtl/video_src_gen_pkg.sv
// Shared types and constants for the video source stage: coordinate struct,
// coordinate field widths, register map and FSM states.
`ifndef VIDEO_SRC_GEN_DEFS
`define VIDEO_SRC_GEN_DEFS
`define H_SIZE 10
`define V_SIZE 10
`endif

package video_src_gen_pkg;

    localparam int HC_W = `H_SIZE;
    localparam int VC_W = `V_SIZE;

    // Pixel coordinate carried alongside every beat.
    typedef struct packed {
        logic [VC_W-1:0] vc;
        logic [HC_W-1:0] hc;
    } vga_fc_t;

    // Register select on avs_address.
    localparam logic ADDR_CTRL   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    // Bit positions inside the ctrl and status words.
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_RGB_LSB     = 16;
    localparam int STAT_OVR_BIT     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } src_state_t;

endpackage

// File: rtl/video_src_gen_cnt.sv
// Horizontal/vertical sweep counter. Advances one pixel per accepted beat and
// flags the last pixel of a line and the last line of a frame.
module video_src_gen_cnt
    import video_src_gen_pkg::*;
#(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output logic            line_end,
    output logic            last_line
);

    assign line_end  = (hc == HC_W'(H_DISP - 1));
    assign last_line = (vc == VC_W'(V_DISP - 1));

    // Step the sweep on each handshake, wrapping at line and frame ends.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc <= '0;
            vc <= '0;
        end else if (adv) begin
            if (line_end) begin
                hc <= '0;
                vc <= last_line ? '0 : vc + VC_W'(1);
            end else begin
                hc <= hc + HC_W'(1);
            end
        end
    end

endmodule

// File: rtl/video_src_gen.sv
// Frame source stage: emits one valid/ready beat per active pixel with a
// constant fill colour, started by frame_start from display timing.
// Optional build macro VIDEO_SRC_FRAME_CNT_EN adds a 16-bit frame counter
// reported in status[31:16]; without it those bits read 0.
module video_src_gen
    import video_src_gen_pkg::*;
#(
    parameter int RGB_SIZE = 12,   // colour width, at most 16
    parameter int H_DISP   = 640,
    parameter int V_DISP   = 480
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                avs_write,
    input  logic                avs_read,
    input  logic                avs_address,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    input  logic                frame_start,
    input  logic                snk_rdy,
    output logic                snk_vld,
    output vga_fc_t             snk_fc,
    output logic [RGB_SIZE-1:0] snk_rgb
);

    src_state_t          state, state_nxt;
    logic                ctrl_en, ctrl_oneshot;
    logic [RGB_SIZE-1:0] ctrl_rgb;
    logic                overrun;
    logic [15:0]         frame_cnt;
    logic                ctrl_wr, stat_wr;
    logic                adv, line_end, last_line, eof_hs, clr_en;
    logic [31:0]         ctrl_rd, stat_rd;
    logic                unused_wdata;

    assign ctrl_wr = avs_write && (avs_address == ADDR_CTRL);
    assign stat_wr = avs_write && (avs_address == ADDR_STATUS);
    assign snk_vld = (state == ST_RUN);
    assign adv     = snk_vld && snk_rdy;
    assign eof_hs  = adv && line_end && last_line;

    // Reduction keeps the reserved write-data bits referenced.
    assign unused_wdata = ^avs_writedata;

    video_src_gen_cnt #(
        .H_DISP (H_DISP),
        .V_DISP (V_DISP)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .hc        (snk_fc.hc),
        .vc        (snk_fc.vc),
        .line_end  (line_end),
        .last_line (last_line)
    );

    // Next-state logic; a started frame always runs to its last pixel.
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        clr_en    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ctrl_en) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!ctrl_en)        state_nxt = ST_IDLE;
                else if (frame_start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (eof_hs) begin
                    if (ctrl_en && !ctrl_oneshot) begin
                        state_nxt = ST_ARMED;
                    end else begin
                        state_nxt = ST_IDLE;
                        clr_en    = ctrl_oneshot;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Ctrl register; a oneshot frame drops enable when it finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_en      <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ctrl_rgb     <= '0;
        end else if (ctrl_wr) begin
            ctrl_en      <= avs_writedata[CTRL_EN_BIT];
            ctrl_oneshot <= avs_writedata[CTRL_ONESHOT_BIT];
            ctrl_rgb     <= avs_writedata[CTRL_RGB_LSB +: RGB_SIZE];
        end else if (clr_en) begin
            ctrl_en      <= 1'b0;
        end
    end

    // Freeze the fill colour for the whole frame at RUN entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snk_rgb <= '0;
        end else if (state != ST_RUN && state_nxt == ST_RUN) begin
            snk_rgb <= ctrl_rgb;
        end
    end

    // Sticky overrun: a frame_start that lands while a frame is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (state == ST_RUN && frame_start) begin
            overrun <= 1'b1;
        end else if (stat_wr && avs_writedata[STAT_OVR_BIT]) begin
            overrun <= 1'b0;
        end
    end

`ifdef VIDEO_SRC_FRAME_CNT_EN
    // Count completed frames, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        frame_cnt <= '0;
        else if (eof_hs) frame_cnt <= frame_cnt + 16'd1;
    end
`else
    assign frame_cnt = '0;
`endif

    // Assemble the readable register images.
    always_comb begin
        ctrl_rd                              = '0;
        ctrl_rd[CTRL_EN_BIT]                 = ctrl_en;
        ctrl_rd[CTRL_ONESHOT_BIT]            = ctrl_oneshot;
        ctrl_rd[CTRL_RGB_LSB +: RGB_SIZE]    = ctrl_rgb;
        stat_rd                              = '0;
        stat_rd[0]                           = (state == ST_RUN);
        stat_rd[1]                           = (state == ST_ARMED);
        stat_rd[STAT_OVR_BIT]                = overrun;
        stat_rd[31:16]                       = frame_cnt;
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= (avs_address == ADDR_STATUS) ? stat_rd : ctrl_rd;
        end
    end

endmodule

// File: tb/tb_video_src_gen.sv
// Self-checking bench for video_src_gen on a reduced 8x4 raster. Expected
// beats are queued when a frame is started and popped as the DUT emits them.
module tb_video_src_gen;
    import video_src_gen_pkg::*;

    localparam int TB_H   = 8;
    localparam int TB_V   = 4;
    localparam int TB_RGB = 12;

    typedef struct {
        vga_fc_t           fc;
        logic [TB_RGB-1:0] rgb;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              avs_write = 1'b0;
    logic              avs_read = 1'b0;
    logic              avs_address = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic              frame_start = 1'b0;
    logic              snk_rdy = 1'b0;
    logic              snk_vld;
    vga_fc_t           snk_fc;
    logic [TB_RGB-1:0] snk_rgb;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    video_src_gen #(
        .RGB_SIZE (TB_RGB),
        .H_DISP   (TB_H),
        .V_DISP   (TB_V)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .avs_write     (avs_write),
        .avs_read      (avs_read),
        .avs_address   (avs_address),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .frame_start   (frame_start),
        .snk_rdy       (snk_rdy),
        .snk_vld       (snk_vld),
        .snk_fc        (snk_fc),
        .snk_rgb       (snk_rgb)
    );

    task automatic avs_wr(input logic addr, input logic [31:0] data);
        @(negedge clk);
        avs_write = 1'b1; avs_address = addr; avs_writedata = data;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic addr, output logic [31:0] data);
        @(negedge clk);
        avs_read = 1'b1; avs_address = addr;
        @(negedge clk);
        avs_read = 1'b0;
        data = avs_readdata;
    endtask

    // Pulse frame_start and queue the full raster the DUT owes us.
    task automatic start_frame(input logic [TB_RGB-1:0] rgb);
        beat_t e;
        @(negedge clk);
        frame_start = 1'b1;
        for (int v = 0; v < TB_V; v++) begin
            for (int h = 0; h < TB_H; h++) begin
                e.fc.hc = HC_W'(h);
                e.fc.vc = VC_W'(v);
                e.rgb   = rgb;
                exp_q.push_back(e);
            end
        end
    endtask

    // Consume one frame: random ready, optional mid-frame frame_start,
    // frame_start on the last handshake, or an enable-clearing ctrl write.
    task automatic drain(input int rdy_pct, input int pulse_at,
                         input bit pulse_eof, input int clr_at);
        int cyc  = 0;
        bit done = 1'b0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            frame_start = 1'b0;
            avs_write   = 1'b0;
            if (cyc == 0) begin
                n_tests++;
                if (snk_vld !== 1'b1) begin
                    n_fail++;
                    $display("FAIL first_beat_latency: snk_vld=%b expected 1", snk_vld);
                end
            end
            if (cyc == pulse_at) frame_start = 1'b1;
            if (cyc == clr_at) begin
                avs_write = 1'b1; avs_address = ADDR_CTRL; avs_writedata = '0;
            end
            snk_rdy = ($urandom_range(99) < rdy_pct);
            if (snk_vld === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat: hc=%0d vc=%0d with nothing expected",
                             snk_fc.hc, snk_fc.vc);
                    done = 1'b1;
                end else begin
                    if (snk_fc !== exp_q[0].fc || snk_rgb !== exp_q[0].rgb) begin
                        n_fail++;
                        $display("FAIL beat: got hc=%0d vc=%0d rgb=%h expected hc=%0d vc=%0d rgb=%h",
                                 snk_fc.hc, snk_fc.vc, snk_rgb,
                                 exp_q[0].fc.hc, exp_q[0].fc.vc, exp_q[0].rgb);
                    end
                    if (snk_rdy) begin
                        if (exp_q.size() == 1) begin
                            done = 1'b1;
                            if (pulse_eof) frame_start = 1'b1;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            cyc++;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL frame_timeout: %0d beats still pending", exp_q.size());
        end
        @(negedge clk);
        frame_start = 1'b0;
        avs_write   = 1'b0;
        snk_rdy     = 1'b0;
        n_tests++;
        if (snk_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL vld_after_eof: snk_vld=%b expected 0", snk_vld);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        repeat (3) @(negedge clk);
        n_tests++;
        if (snk_vld !== 1'b0 || snk_fc !== '0 || snk_rgb !== '0 || avs_readdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: vld=%b fc=%h rgb=%h rd=%h expected all 0",
                     snk_vld, snk_fc, snk_rgb, avs_readdata);
        end
        rst = 1'b1;
        avs_rd(ADDR_CTRL, rd);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h expected 00000000", rd);
        end
        avs_rd(ADDR_STATUS, rd);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_status: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_armed_idle();
        logic [31:0] rd;
        bit          seen = 1'b0;
        avs_wr(ADDR_CTRL, 32'h0000_0001);
        repeat (10) begin
            @(negedge clk);
            if (snk_vld !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL armed_no_start: snk_vld rose without frame_start");
        end
        avs_rd(ADDR_STATUS, rd);
        n_tests++;
        if (rd !== 32'h0000_0002) begin
            n_fail++; $display("FAIL armed_status: got %h expected 00000002", rd);
        end
    endtask

    task automatic test_full_frame();
        logic [31:0] rd;
        avs_wr(ADDR_CTRL, 32'h0ABC_0001);
        start_frame(12'hABC);
        drain(100, -1, 1'b0, -1);
        avs_rd(ADDR_STATUS, rd);
        n_tests++;
        if (rd[15:0] !== 16'h0002) begin
            n_fail++; $display("FAIL full_frame_rearm: status=%h expected low 0002", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        avs_wr(ADDR_CTRL, 32'h0DEF_0001);
        start_frame(12'hDEF);
        drain(50, -1, 1'b0, 10);
        avs_rd(ADDR_STATUS, rd);
        n_tests++;
        if (rd[15:0] !== 16'h0000) begin
            n_fail++; $display("FAIL disable_midframe_idle: status=%h expected low 0000", rd);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        bit          seen = 1'b0;
        avs_wr(ADDR_CTRL, 32'h0123_0003);
        start_frame(12'h123);
        drain(100, -1, 1'b0, -1);
        avs_rd(ADDR_STATUS, rd);
        n_tests++;
        if (rd[15:0] !== 16'h0000) begin
            n_fail++; $display("FAIL oneshot_idle: status=%h expected low 0000", rd);
        end
        avs_rd(ADDR_CTRL, rd);
        n_tests++;
        if (rd !== 32'h0123_0002) begin
            n_fail++; $display("FAIL oneshot_ctrl: got %h expected 01230002", rd);
        end
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (8) begin
            if (snk_vld !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL oneshot_no_second: frame started after oneshot");
        end
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        avs_wr(ADDR_CTRL, 32'h0555_0001);
        start_frame(12'h555);
        drain(100, 5, 1'b0, -1);
        avs_rd(ADDR_STATUS, rd);
        n_tests++;
        if (rd[2:0] !== 3'b110) begin
            n_fail++; $display("FAIL overrun_set: status=%h expected low bits 110", rd);
        end
        avs_wr(ADDR_STATUS, 32'h0000_0004);
        avs_rd(ADDR_STATUS, rd);
        n_tests++;
        if (rd[2:0] !== 3'b010) begin
            n_fail++; $display("FAIL overrun_clear: status=%h expected low bits 010", rd);
        end
        start_frame(12'h555);
        drain(100, -1, 1'b1, -1);
        avs_rd(ADDR_STATUS, rd);
        n_tests++;
        if (rd[2:0] !== 3'b110) begin
            n_fail++; $display("FAIL overrun_eof: status=%h expected low bits 110", rd);
        end
        avs_wr(ADDR_STATUS, 32'h0000_0004);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        start_frame(12'h555);
        repeat (5) begin
            @(negedge clk);
            frame_start = 1'b0;
            snk_rdy     = 1'b1;
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (snk_vld !== 1'b0 || snk_fc !== '0 || snk_rgb !== '0 || avs_readdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: vld=%b fc=%h rgb=%h rd=%h expected all 0",
                     snk_vld, snk_fc, snk_rgb, avs_readdata);
        end
        exp_q.delete();
        snk_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        avs_rd(ADDR_STATUS, rd);
        n_tests++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_frame_status: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_frame_count();
        logic [31:0] rd;
        logic [15:0] exp_cnt;
`ifdef VIDEO_SRC_FRAME_CNT_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        avs_wr(ADDR_CTRL, 32'h0777_0001);
        for (int f = 0; f < 3; f++) begin
            start_frame(12'h777);
            drain(100, -1, 1'b0, -1);
        end
        avs_rd(ADDR_STATUS, rd);
        n_tests++;
        if (rd !== {exp_cnt, 16'h0002}) begin
            n_fail++;
            $display("FAIL frame_count: status=%h expected %h", rd, {exp_cnt, 16'h0002});
        end
    endtask

    initial begin
        test_reset();
        test_armed_idle();
        test_full_frame();
        test_backpressure();
        test_oneshot();
        test_overrun();
        test_reset_mid_frame();
        test_frame_count();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
